// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder:
// FSM state encoding, wait-counter width and byte-lane count.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data memory (slave).
// access_fault exists only when DMEM_ACCESS_FAULT_EN is defined.
interface data_mem_responder_if;

  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rd_data;
  logic        ready;
  logic        busy;
`ifdef DMEM_ACCESS_FAULT_EN
  logic        access_fault;
`endif

  modport master (
    output addr, wr_data, wr_mask, mem_read, mem_write,
    input  rd_data, ready, busy
`ifdef DMEM_ACCESS_FAULT_EN
    , input access_fault
`endif
  );

  modport slave (
    input  addr, wr_data, wr_mask, mem_read, mem_write,
    output rd_data, ready, busy
`ifdef DMEM_ACCESS_FAULT_EN
    , output access_fault
`endif
  );

endinterface

// File: rtl/byte_lane_ram.sv
// Word memory built from one 8-bit array per byte lane, each with its own write
// enable and a registered read-first port (read returns the pre-write contents).
module byte_lane_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we,
  input  logic                 re,
  input  logic [IDX_W-1:0]     idx,
  input  logic [8*LANES-1:0]   wdata,
  output logic [8*LANES-1:0]   rdata
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        mem[idx] <= wdata[8*gi +: 8];
      end
      if (re) begin
        q_reg <= mem[idx];
      end
    end

    assign rdata[8*gi +: 8] = q_reg;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches a MEM-stage request, waits LATENCY cycles, then performs
// a byte-masked write or full-word read and pulses ready. Optional DMEM_ACCESS_FAULT_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic              clk,
  input logic              rst,
  data_mem_responder_if.slave bus
);

  localparam int             IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [LANES-1:0] mask_reg;
  logic             op_rd_reg;
  logic             op_wr_reg;
  logic             fault_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             rd_zero_reg;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx_next;
  logic             fault_next;
  logic             access;
  logic [LANES-1:0] ram_we;
  logic             ram_re;
  logic [31:0]      ram_q;

  // addr[1:0] drops out with the shift; upper bits wrap modulo DEPTH_WORDS
  assign offset   = bus.addr - BASE_ADDR;
  assign idx_next = IDX_W'(offset >> 2);

`ifdef DMEM_ACCESS_FAULT_EN
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  logic fault_out_reg;

  assign fault_next = ({1'b0, bus.addr} < {1'b0, BASE_ADDR}) ||
                      ({1'b0, bus.addr} >= ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_out_reg <= 1'b0;
    end else begin
      fault_out_reg <= (state_reg == ST_DONE) && fault_reg;
    end
  end

  assign bus.access_fault = fault_out_reg;
`else
  assign fault_next = 1'b0;
`endif

  // reset gates the enables so an aborted transaction never touches the array
  assign access = (state_reg == ST_BUSY) && (cnt_reg == '0);
  assign ram_we = (access && op_wr_reg && !fault_reg && !rst) ? mask_reg : '0;
  assign ram_re = access && op_rd_reg && !fault_reg && !rst;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (idx_reg),
    .wdata(wdata_reg),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      rd_zero_reg <= 1'b1;
      fault_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b0;
          if (bus.mem_read || bus.mem_write) begin
            idx_reg   <= idx_next;
            wdata_reg <= bus.wr_data;
            mask_reg  <= bus.wr_mask;
            op_rd_reg <= bus.mem_read;
            op_wr_reg <= bus.mem_write;
            fault_reg <= fault_next;
            cnt_reg   <= LAT_INIT;
            busy_reg  <= 1'b1;
            state_reg <= ST_BUSY;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_reg == '0) begin
            // rd_data is the RAM read register unless a fault or reset zeroed it
            if (fault_reg) begin
              rd_zero_reg <= 1'b1;
            end else if (op_rd_reg) begin
              rd_zero_reg <= 1'b0;
            end
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_DONE: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_data = rd_zero_reg ? '0 : ram_q;
  assign bus.ready   = ready_reg;
  assign bus.busy    = busy_reg;

endmodule
